// File: rtl/tick_count_stage_if.sv
// Control/status bundle between a controller and one tick counting stage.
// The master drives control and limit; the slave (the stage) returns status.
interface tick_count_stage_if #(
    parameter int unsigned WIDTH = 6
);
    logic             go;
    logic             enable;
    logic             clear;
    logic             start;
    logic             stop;
    logic             mode;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic             carry;
    logic             done;
    logic             busy;

    modport master (
        output go, enable, clear, start, stop, mode, limit,
        input  count, carry, done, busy
    );

    modport slave (
        input  go, enable, clear, start, stop, mode, limit,
        output count, carry, done, busy
    );
endinterface

// File: rtl/tick_count_stage.sv
// Downstream stage of the prescaler: counts qualified 'go' ticks modulo a
// programmable limit and emits a one-cycle carry per wrap for cascading.
// Periodic or one-shot operation under an IDLE/RUN/DONE state machine.
// All outputs are registered.
module tick_count_stage #(
    parameter int unsigned WIDTH = 6
) (
    input logic               clk,
    input logic               reset_n,
    tick_count_stage_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic             carry_q;
    logic             done_q;
    logic             busy_q;

    logic             tick;
    logic [WIDTH-1:0] term;
    logic             wrap;

    // Qualified tick and terminal count; limit 0 means a full 2**WIDTH modulus.
    always_comb begin
        tick = bus.go & bus.enable & (state_q == StRun);
        term = (bus.limit == '0) ? '1 : (bus.limit - WIDTH'(1));
        // >= so that lowering the limit below the current count wraps on the next tick
        wrap = (count_q >= term);
    end

    // State machine with registered outputs; priority clear > stop > start > tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            count_q <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            carry_q <= 1'b0;
            if (bus.clear) begin
                state_q <= StIdle;
                count_q <= '0;
                done_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        count_q <= '0;
                        // go in the start cycle is deliberately dropped
                        if (bus.start) begin
                            state_q <= StRun;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                    StRun: begin
                        if (bus.stop) begin
                            // stop beats a wrapping tick: no carry is emitted
                            state_q <= StIdle;
                            count_q <= '0;
                            busy_q  <= 1'b0;
                        end else if (tick) begin
                            if (wrap) begin
                                count_q <= '0;
                                carry_q <= 1'b1;
                                // mode is sampled only at the wrap
                                if (bus.mode) begin
                                    state_q <= StDone;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end
                            end else begin
                                count_q <= count_q + WIDTH'(1);
                            end
                        end
                    end
                    StDone: begin
                        count_q <= '0;
                        if (bus.stop) begin
                            state_q <= StIdle;
                            done_q  <= 1'b0;
                        end else if (bus.start) begin
                            state_q <= StRun;
                            done_q  <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        count_q <= '0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Registered state drives the interface directly.
    always_comb begin
        bus.count = count_q;
        bus.carry = carry_q;
        bus.done  = done_q;
        bus.busy  = busy_q;
    end

endmodule

// File: tb/tb_tick_count_stage.sv
// Directed bench for tick_count_stage (WIDTH=6). Inputs are driven and outputs
// sampled on the falling edge, away from the active rising edge.
module tb_tick_count_stage;

    localparam int unsigned WIDTH = 6;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;
    int   carries;

    tick_count_stage_if #(.WIDTH(WIDTH)) bus ();

    tick_count_stage #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // One-cycle go pulse; outputs reflect the tick when this returns.
    task automatic pulse_go();
        bus.go = 1'b1;
        cyc();
        bus.go = 1'b0;
    endtask

    task automatic check_outs(input string tag, input int cnt, input logic cy,
                              input logic dn, input logic bz);
        check({tag, ".count"}, 32'(bus.count), 32'(cnt));
        check({tag, ".carry"}, 32'(bus.carry), 32'(cy));
        check({tag, ".done"},  32'(bus.done),  32'(dn));
        check({tag, ".busy"},  32'(bus.busy),  32'(bz));
    endtask

    // Watchdog: the sequence is fixed-length, this only guards against a stall.
    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        bus.go = 1'b0; bus.enable = 1'b1; bus.clear = 1'b0; bus.start = 1'b0;
        bus.stop = 1'b0; bus.mode = 1'b0; bus.limit = 6'd4;
        cyc(); cyc();
        check_outs("reset", 0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        cyc();

        // 1: periodic, limit 4, go pulses 3 clocks apart
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        check_outs("t1.start", 0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            pulse_go();
            check_outs($sformatf("t1.go%0d", i), i % 4, (i % 4) == 0, 1'b0, 1'b1);
            cyc();
            check("t1.carry_gap", 32'(bus.carry), 32'd0);
            cyc();
        end

        // 2: one-shot, limit 3
        bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
        check_outs("t2.stop", 0, 1'b0, 1'b0, 1'b0);
        bus.limit = 6'd3; bus.mode = 1'b1;
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        pulse_go(); check("t2.go1.count", 32'(bus.count), 32'd1);
        pulse_go(); check("t2.go2.count", 32'(bus.count), 32'd2);
        pulse_go(); check_outs("t2.go3", 0, 1'b1, 1'b1, 1'b0);
        cyc();      check_outs("t2.after", 0, 1'b0, 1'b1, 1'b0);
        pulse_go(); pulse_go();
        check_outs("t2.done_go", 0, 1'b0, 1'b1, 1'b0);
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        check_outs("t2.restart", 0, 1'b0, 1'b0, 1'b1);

        // 3: limit 0 is a 64 modulus, then limit 1 wraps every tick
        bus.mode = 1'b0; bus.limit = 6'd0;
        carries = 0;
        for (int i = 1; i <= 63; i++) begin
            pulse_go();
            if (bus.carry) carries++;
        end
        check("t3.count63", 32'(bus.count), 32'd63);
        check("t3.no_early_carry", 32'(carries), 32'd0);
        pulse_go();
        check_outs("t3.wrap64", 0, 1'b1, 1'b0, 1'b1);
        cyc(); check("t3.carry_once", 32'(bus.carry), 32'd0);
        bus.limit = 6'd1;
        for (int i = 0; i < 3; i++) begin
            pulse_go();
            check_outs($sformatf("t3.lim1_%0d", i), 0, 1'b1, 1'b0, 1'b1);
            cyc();
            check("t3.lim1_gap", 32'(bus.carry), 32'd0);
        end

        // 4: lowering limit below count wraps on the next tick
        bus.limit = 6'd8;
        for (int i = 0; i < 5; i++) pulse_go();
        check("t4.count5", 32'(bus.count), 32'd5);
        bus.limit = 6'd3;
        pulse_go();
        check_outs("t4.lowered", 0, 1'b1, 1'b0, 1'b1);

        // 5: enable low freezes, start+go in IDLE, stop beats wrap
        bus.limit = 6'd8;
        pulse_go(); pulse_go();
        check("t5.count2", 32'(bus.count), 32'd2);
        bus.enable = 1'b0;
        pulse_go(); cyc(); pulse_go();
        check_outs("t5.frozen", 2, 1'b0, 1'b0, 1'b1);
        bus.enable = 1'b1;
        cyc(); check("t5.not_queued", 32'(bus.count), 32'd2);
        bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
        check_outs("t5.stop", 0, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b1; bus.go = 1'b1; cyc(); bus.start = 1'b0; bus.go = 1'b0;
        check_outs("t5.start_go", 0, 1'b0, 1'b0, 1'b1);
        bus.limit = 6'd1;
        bus.stop = 1'b1; bus.go = 1'b1; cyc(); bus.stop = 1'b0; bus.go = 1'b0;
        check_outs("t5.stop_wrap", 0, 1'b0, 1'b0, 1'b0);

        // 6: async reset mid-run, clear priority
        bus.limit = 6'd8;
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        pulse_go(); pulse_go();
        check("t6.count2", 32'(bus.count), 32'd2);
        #2 reset_n = 1'b0;
        #1 check_outs("t6.async_rst", 0, 1'b0, 1'b0, 1'b0);
        cyc(); reset_n = 1'b1;
        cyc(); check_outs("t6.release", 0, 1'b0, 1'b0, 1'b0);
        bus.clear = 1'b1; bus.start = 1'b1; cyc(); bus.clear = 1'b0; bus.start = 1'b0;
        check_outs("t6.clear_start", 0, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        pulse_go();
        check("t6.run_count1", 32'(bus.count), 32'd1);
        bus.clear = 1'b1; bus.go = 1'b1; cyc(); bus.clear = 1'b0; bus.go = 1'b0;
        check_outs("t6.clear_run", 0, 1'b0, 1'b0, 1'b0);
        bus.limit = 6'd1; bus.mode = 1'b1;
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        pulse_go();
        check_outs("t6.oneshot", 0, 1'b1, 1'b1, 1'b0);
        bus.clear = 1'b1; cyc(); bus.clear = 1'b0;
        check_outs("t6.clear_done", 0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
